// File: rtl/regfile_writeback_ctrl.sv
// Write-side controller for the register file: buffers MEM/WB results, drives the
// registered write port, and keeps a per-register in-flight scoreboard for RAW hazards.
module regfile_writeback_ctrl #(
  parameter int DATA_W     = 32,
  parameter int AW         = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PEND_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_dreg,
  output logic                 iss_ready,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [AW-1:0]        res_dreg,
  input  logic [DATA_W-1:0]    res_data,
  input  logic                 res_wen,
  input  logic                 sp_wr_en,
  input  logic                 wb_stall,
  input  logic [AW-1:0]        rd_reg1,
  input  logic [AW-1:0]        rd_reg2,
  output logic                 hazard,
  output logic [2**AW-1:0]     busy,
  output logic                 wb_we,
  output logic [AW-1:0]        wb_dreg,
  output logic [DATA_W-1:0]    wb_data,
  output logic [1:0]           err
);

  localparam int NREG  = 2**AW;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // PC and SP are the two highest-numbered registers (R15/R14 for AW=4)
  localparam logic [AW-1:0] PC_REG = AW'(NREG - 1);
  localparam logic [AW-1:0] SP_REG = AW'(NREG - 2);

  typedef struct packed {
    logic [AW-1:0]     dreg;
    logic [DATA_W-1:0] data;
    logic              wen;
    logic              sp_ok;
  } wb_ent_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_PC    = 2'b01,
    ERR_SP    = 2'b10,
    ERR_UFLOW = 2'b11
  } err_e;

  wb_ent_t                      r_mem [FIFO_DEPTH];
  logic    [PTR_W-1:0]          r_wptr, r_rptr;
  logic    [CNT_W-1:0]          r_cnt;
  logic    [NREG-1:0][PEND_W-1:0] r_pend;

  wb_ent_t w_head;
  logic    w_push, w_pop;
  logic    w_pc_hit, w_sp_deny, w_uflow;

  // Ready comes only from the registered count, so a full FIFO refuses a push
  // even on an edge where the head is popped.
  assign res_ready = (r_cnt < CNT_W'(FIFO_DEPTH));
  assign w_push    = res_valid & res_ready;
  assign w_pop     = ~wb_stall & (r_cnt != '0);
  assign w_head    = r_mem[r_rptr];

  assign w_pc_hit  = (w_head.dreg == PC_REG);
  assign w_sp_deny = (w_head.dreg == SP_REG) & ~w_head.sp_ok;
  assign w_uflow   = w_pop & (r_pend[w_head.dreg] == '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{dreg: res_dreg, data: res_data, wen: res_wen, sp_ok: sp_wr_en};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // One saturating up/down counter per architectural register.
  for (genvar g = 0; g < NREG; g++) begin : g_pend
    logic w_inc, w_hit;
    assign w_inc   = iss_valid & iss_ready & (iss_dreg == AW'(g));
    assign w_hit   = w_pop & (w_head.dreg == AW'(g));
    assign busy[g] = |r_pend[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                      r_pend[g] <= '0;
      else if (w_inc && !w_hit)                        r_pend[g] <= r_pend[g] + PEND_W'(1);
      else if (w_hit && !w_inc && r_pend[g] != '0)     r_pend[g] <= r_pend[g] - PEND_W'(1);
    end
  end

  assign iss_ready = ~&r_pend[iss_dreg];
  assign hazard    = busy[rd_reg1] | busy[rd_reg2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we   <= 1'b0;
      wb_dreg <= '0;
      wb_data <= '0;
      err     <= ERR_NONE;
    end else if (w_pop) begin
      wb_we   <= w_head.wen & ~w_pc_hit & ~w_sp_deny;
      wb_dreg <= w_head.dreg;
      wb_data <= w_head.data;
      if (w_uflow)        err <= ERR_UFLOW;
      else if (w_pc_hit)  err <= ERR_PC;
      else if (w_sp_deny) err <= ERR_SP;
      else                err <= ERR_NONE;
    end else begin
      wb_we <= 1'b0;
      err   <= ERR_NONE;
    end
  end

endmodule
